// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron layer sequencer.
// Optional build macro used by this slice: NEURON_SEQ_STALL_CNT_EN (adds stall_cnt output).
package neuron_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // One read per input, plus one trailing cycle to land the last read word.
    localparam int unsigned FETCH_CYCLES      = 4;
    localparam int unsigned INPUTS_PER_NEURON = 3;
    localparam int          K_W               = $clog2(FETCH_CYCLES);

    typedef enum logic [1:0] {
        NLS_IDLE  = 2'd0,
        NLS_FETCH = 2'd1,
        NLS_EVAL  = 2'd2,
        NLS_OUT   = 2'd3
    } nls_state_t;

    // Word address of input k of a neuron; weight/bias triples are packed back to back.
    function automatic int unsigned weight_addr(input int unsigned idx, input int unsigned k);
        return idx * INPUTS_PER_NEURON + k;
    endfunction

endpackage

// File: rtl/nls_fetch_ctrl.sv
// Weight-fetch controller: walks the k counter through one neuron's fetch window,
// issues the three memory reads and tells the top which operand slot to capture.
// A read issued at k lands one cycle later, so the capture slot trails k by one.
module nls_fetch_ctrl
    import neuron_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active,
    input  logic [IDX_W-1:0]  neuron_idx,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              cap_en,
    output logic [K_W-1:0]    cap_slot,
    output logic              done
);

    localparam logic [K_W-1:0] K_LAST  = K_W'(FETCH_CYCLES - 1);
    localparam logic [K_W-1:0] K_READS = K_W'(INPUTS_PER_NEURON);

    logic [K_W-1:0] k;

    // k advances once per fetch cycle and sits at zero outside the fetch window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= '0;
        end else if (!active || (k == K_LAST)) begin
            k <= '0;
        end else begin
            k <= k + K_W'(1);
        end
    end

    // Read strobe, address and capture strobe decoded from k; address parks at 0 when idle.
    always_comb begin
        mem_en   = active && (k < K_READS);
        mem_addr = '0;
        if (mem_en) begin
            mem_addr = ADDR_W'(weight_addr(32'(neuron_idx), 32'(k)));
        end
        cap_en   = active && (k != '0);
        cap_slot = k - K_W'(1);
        done     = active && (k == K_LAST);
    end

endmodule

// File: rtl/neuron_layer_seq.sv
// Neuron layer sequencer: time-multiplexes one external 3-input neuron datapath
// across N_NEURON neurons, fetching weights/biases and streaming one result per neuron.
// Optional build macro: NEURON_SEQ_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// NLS_IDLE  | waiting for an activation vector, in_ready high
// NLS_FETCH | reading this neuron's three {b,w} words into nu_w/nu_b
// NLS_EVAL  | operands stable, capture datapath result and index
// NLS_OUT   | result presented on out_*, held until out_ready
module neuron_layer_seq
    import neuron_pkg::*;
#(
    parameter int  WIDTH    = WIDTH_DEFAULT,
    parameter int  N_NEURON = 4,
    parameter int  ADDR_W   = 4,
    localparam int IDX_W    = (N_NEURON > 1) ? $clog2(N_NEURON) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*WIDTH-1:0] in_a,
    output logic               mem_en,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [2*WIDTH-1:0] mem_rdata,
    output logic [3*WIDTH-1:0] nu_a,
    output logic [3*WIDTH-1:0] nu_w,
    output logic [3*WIDTH-1:0] nu_b,
    input  logic [WIDTH-1:0]   nu_y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_last
`ifdef NEURON_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

    nls_state_t       state_q, state_d;
    logic [IDX_W-1:0] neuron_idx;
    logic             fetch_active;
    logic             fetch_done;
    logic             cap_en;
    logic [K_W-1:0]   cap_slot;
    logic             accept;
    logic             out_fire;

    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    nls_fetch_ctrl #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_fetch (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (fetch_active),
        .neuron_idx (neuron_idx),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .cap_en     (cap_en),
        .cap_slot   (cap_slot),
        .done       (fetch_done)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NLS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        fetch_active = 1'b0;
        case (state_q)
            NLS_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = NLS_FETCH;
                end
            end
            NLS_FETCH: begin
                fetch_active = 1'b1;
                if (fetch_done) begin
                    state_d = NLS_EVAL;
                end
            end
            NLS_EVAL: begin
                state_d = NLS_OUT;
            end
            NLS_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = out_last ? NLS_IDLE : NLS_FETCH;
                end
            end
            default: begin
                state_d = NLS_IDLE;
            end
        endcase
    end

    // Neuron index: restarts with each vector, steps on every non-final result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neuron_idx <= '0;
        end else if (accept) begin
            neuron_idx <= '0;
        end else if (out_fire && !out_last) begin
            neuron_idx <= neuron_idx + IDX_W'(1);
        end
    end

    // Activations are latched once and held for every neuron of the vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nu_a <= '0;
        end else if (accept) begin
            nu_a <= in_a;
        end
    end

    // Weight/bias operand slots, loaded only while fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nu_w <= '0;
            nu_b <= '0;
        end else if (cap_en) begin
            for (int s = 0; s < int'(INPUTS_PER_NEURON); s++) begin
                if (cap_slot == K_W'(s)) begin
                    nu_w[s*WIDTH +: WIDTH] <= mem_rdata[WIDTH-1:0];
                    nu_b[s*WIDTH +: WIDTH] <= mem_rdata[2*WIDTH-1:WIDTH];
                end
            end
        end
    end

    // Result registers: loaded in EVAL, held through OUT; out_last drops after the final handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
        end else if (state_q == NLS_EVAL) begin
            out_data <= nu_y;
            out_idx  <= neuron_idx;
            out_last <= (neuron_idx == LAST_IDX);
        end else if (out_fire && out_last) begin
            out_last <= 1'b0;
        end
    end

`ifdef NEURON_SEQ_STALL_CNT_EN
    // Counts cycles a result waits on downstream; restarts with each vector, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Testbench for neuron_layer_seq: a two-neuron instance and a one-neuron instance,
// each with a synchronous weight memory and a combinational mock datapath.
module tb_neuron_layer_seq;

    localparam int W  = 32;
    localparam int AW = 4;
    localparam int N2 = 2;
    localparam int N1 = 1;

    logic clk;
    logic rst_n;

    // two-neuron instance
    logic           in_valid, in_ready;
    logic [3*W-1:0] in_a;
    logic           mem_en;
    logic [AW-1:0]  mem_addr;
    logic [2*W-1:0] mem_rdata;
    logic [3*W-1:0] nu_a, nu_w, nu_b;
    logic [W-1:0]   nu_y;
    logic           out_valid, out_ready;
    logic [W-1:0]   out_data;
    logic [0:0]     out_idx;
    logic           out_last;

    // one-neuron instance
    logic           in_valid_1, in_ready_1;
    logic [3*W-1:0] in_a_1;
    logic           mem_en_1;
    logic [AW-1:0]  mem_addr_1;
    logic [2*W-1:0] mem_rdata_1;
    logic [3*W-1:0] nu_a_1, nu_w_1, nu_b_1;
    logic [W-1:0]   nu_y_1;
    logic           out_valid_1, out_ready_1;
    logic [W-1:0]   out_data_1;
    logic [0:0]     out_idx_1;
    logic           out_last_1;

`ifdef NEURON_SEQ_STALL_CNT_EN
    logic [15:0] stall_cnt, stall_cnt_1;
`endif

    logic [2*W-1:0] mem2 [16];
    logic [2*W-1:0] mem1 [16];
    logic [AW-1:0]  addr_log2[$];
    logic [AW-1:0]  addr_log1[$];

    int vectors;
    int miscompares;

    neuron_layer_seq #(.WIDTH(W), .N_NEURON(N2), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .nu_a(nu_a), .nu_w(nu_w), .nu_b(nu_b), .nu_y(nu_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last)
`ifdef NEURON_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    neuron_layer_seq #(.WIDTH(W), .N_NEURON(N1), .ADDR_W(AW)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_1), .in_ready(in_ready_1), .in_a(in_a_1),
        .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_rdata(mem_rdata_1),
        .nu_a(nu_a_1), .nu_w(nu_w_1), .nu_b(nu_b_1), .nu_y(nu_y_1),
        .out_valid(out_valid_1), .out_ready(out_ready_1), .out_data(out_data_1),
        .out_idx(out_idx_1), .out_last(out_last_1)
`ifdef NEURON_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_cnt_1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mock datapath: y = sum(a_k*w_k + b_k), wrapped to W bits
    function automatic logic [W-1:0] mock_dp(input logic [3*W-1:0] a, input logic [3*W-1:0] w,
                                             input logic [3*W-1:0] b);
        logic [W-1:0] acc;
        acc = '0;
        for (int k = 0; k < 3; k++) acc = acc + a[k*W +: W] * w[k*W +: W] + b[k*W +: W];
        return acc;
    endfunction

    assign nu_y   = mock_dp(nu_a, nu_w, nu_b);
    assign nu_y_1 = mock_dp(nu_a_1, nu_w_1, nu_b_1);

    always @(posedge clk) if (mem_en)   mem_rdata   <= mem2[mem_addr];
    always @(posedge clk) if (mem_en_1) mem_rdata_1 <= mem1[mem_addr_1];

    // read-address monitors, including the address-range boundary
    always @(negedge clk) begin
        if (mem_en) begin
            addr_log2.push_back(mem_addr);
            vectors++;
            if (int'(mem_addr) > 3*N2-1) begin
                miscompares++;
                $display("FAIL addr_range2: mem_addr=%0d limit=%0d", mem_addr, 3*N2-1);
            end
        end
        if (mem_en_1) begin
            addr_log1.push_back(mem_addr_1);
            vectors++;
            if (int'(mem_addr_1) > 3*N1-1) begin
                miscompares++;
                $display("FAIL addr_range1: mem_addr=%0d limit=%0d", mem_addr_1, 3*N1-1);
            end
        end
    end

    // reference model: neuron n of a layer, straight from the weight table
    function automatic logic [W-1:0] model_y(input logic [3*W-1:0] a, input int n, input bit one);
        logic [W-1:0]   acc;
        logic [2*W-1:0] word;
        acc = '0;
        for (int k = 0; k < 3; k++) begin
            word = one ? mem1[3*n+k] : mem2[3*n+k];
            acc  = acc + a[k*W +: W] * word[W-1:0] + word[2*W-1:W];
        end
        return acc;
    endfunction

    task automatic fill_random;
        for (int i = 0; i < 16; i++) begin
            mem2[i] = {$urandom, $urandom};
            mem1[i] = {$urandom, $urandom};
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, mem_en, out_last} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 1000", {in_ready, out_valid, mem_en, out_last});
        end
        vectors++;
        if ({mem_addr, nu_a, nu_w, nu_b, out_data, out_idx} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: addr=%0d out_data=%h idx=%0d not all zero", mem_addr, out_data, out_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        fill_random();
        in_a = {$urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({in_ready, out_valid, mem_en} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_midfetch: got %b want 100", {in_ready, out_valid, mem_en});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (!(mem_en === 1'b1 && mem_addr === 4'd0)) begin
            miscompares++;
            $display("FAIL reset_restart: mem_en=%b mem_addr=%0d want 1/0", mem_en, mem_addr);
        end
        out_ready = 1'b1;
        begin
            int t;
            t = 0;
            while (!in_ready && t < 60) begin
                @(negedge clk);
                t++;
            end
            vectors++;
            if (!in_ready) begin
                miscompares++;
                $display("FAIL reset_drain: in_ready=%b want 1 after %0d cycles", in_ready, t);
            end
        end
    endtask

    task automatic test_single;
        int cyc;
        bit ok;
        logic [AW-1:0] exp_addr[$];
        for (int i = 0; i < 6; i++) mem2[i] = {32'd0, 32'(i + 1)};
        in_a = {32'd3, 32'd2, 32'd1};
        out_ready = 1'b1;
        addr_log2.delete();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 6) begin
            miscompares++;
            $display("FAIL single_latency: first out_valid cycle %0d want 6", cyc);
        end
        vectors++;
        if ({out_data, out_idx, out_last} !== {32'd14, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL single_r0: data=%0d idx=%0d last=%b want 14/0/0", out_data, out_idx, out_last);
        end
        @(negedge clk);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 6) begin
            miscompares++;
            $display("FAIL single_gap: next out_valid after %0d cycles want 6", cyc);
        end
        vectors++;
        if ({out_data, out_idx, out_last} !== {32'd32, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL single_r1: data=%0d idx=%0d last=%b want 32/1/1", out_data, out_idx, out_last);
        end
        @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_last} !== 3'b100) begin
            miscompares++;
            $display("FAIL single_idle: got %b want 100", {in_ready, out_valid, out_last});
        end
        exp_addr = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        ok = (addr_log2.size() == exp_addr.size());
        for (int i = 0; i < exp_addr.size() && ok; i++) if (addr_log2[i] !== exp_addr[i]) ok = 0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_addrs: got %p want %p", addr_log2, exp_addr);
        end
    endtask

    task automatic test_backpressure;
        logic [3*W-1:0] a;
        logic [W-1:0]   d;
        int t;
        bit ok;
        fill_random();
        a = {$urandom, $urandom, $urandom};
        in_a = a;
        out_ready = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (out_data !== model_y(a, 0, 0) || out_idx !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_r0: data=%h idx=%0d want %h/0", out_data, out_idx, model_y(a, 0, 0));
        end
        d = out_data;
        ok = 1;
        for (int j = 0; j < 10; j++) begin
            if (!(out_valid === 1'b1 && out_data === d && out_idx === 1'b0 && mem_en === 1'b0)) ok = 0;
            @(negedge clk);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bp_hold: data=%h idx=%0d mem_en=%b want %h/0/0 throughout", out_data, out_idx, mem_en, d);
        end
`ifdef NEURON_SEQ_STALL_CNT_EN
        vectors++;
        if (stall_cnt !== 16'd10) begin
            miscompares++;
            $display("FAIL bp_stall_cnt: got %0d want 10", stall_cnt);
        end
`endif
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (!(mem_en === 1'b1 && mem_addr === 4'd3)) begin
            miscompares++;
            $display("FAIL bp_release: mem_en=%b mem_addr=%0d want 1/3", mem_en, mem_addr);
        end
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if ({out_data, out_idx, out_last} !== {model_y(a, 1, 0), 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL bp_r1: data=%h idx=%0d last=%b want %h/1/1", out_data, out_idx, out_last, model_y(a, 1, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        for (int v = 0; v < 6; v++) begin
            logic [3*W-1:0] a;
            int n;
            int t;
            fill_random();
            a = {$urandom, $urandom, $urandom};
            in_a = a;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            n = 0;
            t = 0;
            while (n < N2 && t < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    vectors++;
                    if ({out_data, out_idx, out_last} !== {model_y(a, n, 0), 1'(n), (n == N2 - 1)}) begin
                        miscompares++;
                        $display("FAIL random_v%0d_n%0d: data=%h idx=%0d last=%b want %h/%0d/%b", v, n,
                                 out_data, out_idx, out_last, model_y(a, n, 0), n, (n == N2 - 1));
                    end
                    n++;
                end
                @(negedge clk);
                t++;
            end
            vectors++;
            if (n != N2 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL random_v%0d_done: results=%0d in_ready=%b want %0d/1", v, n, in_ready, N2);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [3*W-1:0] a1, a2;
        int n;
        int t;
        bit early;
        fill_random();
        a1 = {$urandom, $urandom, $urandom};
        a2 = {$urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_a = a1;
        in_valid = 1'b1;
        @(negedge clk);
        in_a = a2;
        n = 0;
        t = 0;
        early = 0;
        while (!in_ready && t < 100) begin
            if (out_valid) begin
                vectors++;
                if (out_data !== model_y(a1, n, 0)) begin
                    miscompares++;
                    $display("FAIL b2b_first_n%0d: data=%h want %h", n, out_data, model_y(a1, n, 0));
                end
                n++;
            end
            @(negedge clk);
            t++;
        end
        if (n < N2) early = 1;
        vectors++;
        if (early || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_block: in_ready=%b after %0d results want 1 after %0d", in_ready, n, N2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (!(in_ready === 1'b0 && mem_en === 1'b1 && mem_addr === 4'd0)) begin
            miscompares++;
            $display("FAIL b2b_accept: in_ready=%b mem_en=%b mem_addr=%0d want 0/1/0", in_ready, mem_en, mem_addr);
        end
        n = 0;
        t = 0;
        while (n < N2 && t < 100) begin
            if (out_valid) begin
                vectors++;
                if (out_data !== model_y(a2, n, 0)) begin
                    miscompares++;
                    $display("FAIL b2b_second_n%0d: data=%h want %h", n, out_data, model_y(a2, n, 0));
                end
                n++;
            end
            @(negedge clk);
            t++;
        end
        vectors++;
        if (n != N2) begin
            miscompares++;
            $display("FAIL b2b_second_count: got %0d results want %0d", n, N2);
        end
    endtask

    task automatic test_n1;
        logic [3*W-1:0] a;
        int t;
        int results;
        bit ok;
        fill_random();
        a = {$urandom, $urandom, $urandom};
        addr_log1.delete();
        in_a_1 = a;
        out_ready_1 = 1'b1;
        in_valid_1 = 1'b1;
        @(negedge clk);
        in_valid_1 = 1'b0;
        t = 0;
        results = 0;
        while (!in_ready_1 && t < 40) begin
            if (out_valid_1) begin
                results++;
                vectors++;
                if ({out_data_1, out_idx_1, out_last_1} !== {model_y(a, 0, 1), 1'b0, 1'b1}) begin
                    miscompares++;
                    $display("FAIL n1_result: data=%h idx=%0d last=%b want %h/0/1", out_data_1, out_idx_1,
                             out_last_1, model_y(a, 0, 1));
                end
            end
            @(negedge clk);
            t++;
        end
        repeat (8) begin
            if (out_valid_1) results++;
            @(negedge clk);
        end
        vectors++;
        if (results != 1 || in_ready_1 !== 1'b1) begin
            miscompares++;
            $display("FAIL n1_count: results=%0d in_ready=%b want 1/1", results, in_ready_1);
        end
        ok = (addr_log1.size() == 3);
        for (int i = 0; i < addr_log1.size() && ok; i++) if (int'(addr_log1[i]) != i) ok = 0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL n1_addrs: got %p want 0,1,2", addr_log1);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_valid_1  = 1'b0;
        in_a        = '0;
        in_a_1      = '0;
        out_ready   = 1'b1;
        out_ready_1 = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_n1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
